// File: rtl/bus_pkg.sv
// Shared address map, register addresses and state types for the gb_bus memory responder.
// Decoding of FF46 as the DMA register depends on GB_BUS_DMA_EN.
package bus_pkg;

    localparam logic [15:0] WRAM_BASE   = 16'hC000;
    localparam logic [15:0] ECHO_END    = 16'hFDFF;
    localparam logic [15:0] OAM_BASE    = 16'hFE00;
    localparam logic [15:0] UNUSED_BASE = 16'hFEA0;
    localparam logic [15:0] IO_BASE     = 16'hFF00;
    localparam logic [15:0] HRAM_BASE   = 16'hFF80;

    localparam logic [15:0] IF_ADDR  = 16'hFF0F;
    localparam logic [15:0] DMA_ADDR = 16'hFF46;
    localparam logic [15:0] IE_ADDR  = 16'hFFFF;

    localparam int unsigned OAM_LEN = 160;

    typedef enum logic [2:0] {
        R_EXT, R_WRAM, R_UNUSED, R_IF, R_DMA, R_HRAM, R_IE
    } region_t;

    typedef enum logic [1:0] {
        IDLE, RD, WR
    } dma_state_t;

    // WRAM and its echo share one region; the top masks to addr[12:0].
    function automatic region_t decode(input logic [15:0] a);
        if (a < WRAM_BASE)   return R_EXT;
        if (a <= ECHO_END)   return R_WRAM;
        if (a < UNUSED_BASE) return R_EXT;
        if (a < IO_BASE)     return R_UNUSED;
        if (a == IF_ADDR)    return R_IF;
`ifdef GB_BUS_DMA_EN
        if (a == DMA_ADDR)   return R_DMA;
`endif
        if (a < HRAM_BASE)   return R_EXT;
        if (a == IE_ADDR)    return R_IE;
        return R_HRAM;
    endfunction

endpackage

// File: rtl/gb_bus_oam_dma.sv
// OAM DMA engine: alternates a source read (RD) and an OAM write (WR) for 160 bytes.
module oam_dma
    import bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  src_hi_i,
    input  logic [7:0]  src_data_i,
    output logic [15:0] src_addr_o,
    output logic [15:0] dst_addr_o,
    output logic [7:0]  wdata_o,
    output logic        rd_o,
    output logic        we_o,
    output logic        active_o
);

    dma_state_t state_q;
    logic [7:0] idx_q;
    logic [7:0] src_hi_q;
    logic [7:0] byte_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            src_hi_q <= '0;
            byte_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    src_hi_q <= src_hi_i;
                    idx_q    <= '0;
                    state_q  <= RD;
                end
                RD: begin
                    byte_q  <= src_data_i;
                    state_q <= WR;
                end
                WR: begin
                    idx_q   <= idx_q + 8'd1;
                    state_q <= (idx_q == 8'(OAM_LEN - 1)) ? IDLE : RD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign src_addr_o = {src_hi_q, idx_q};
    assign dst_addr_o = OAM_BASE | {8'h00, idx_q};
    assign wdata_o    = byte_q;
    assign rd_o       = (state_q == RD);
    assign we_o       = (state_q == WR);
    assign active_o   = (state_q != IDLE);

endmodule

// File: rtl/gb_bus.sv
// sm83 memory-side responder: WRAM/HRAM/IF/IE internally, everything else on the external port.
// GB_BUS_DMA_EN adds the FF46 OAM DMA engine, which owns the external port while active.
module gb_bus
    import bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_we,
    input  logic [7:0]  ext_rdata,
    input  logic [4:0]  irq_req,
    input  logic [4:0]  irq_ack,
    output logic [4:0]  irq_pending,
    output logic        dma_active
);

    region_t    region;
    logic [7:0] wram_q [0:8191];
    logic [7:0] hram_q [0:126];
    logic [4:0] if_q, if_d;
    logic [7:0] ie_q;
    logic       cpu_blocked;
    logic       cpu_we;

    assign region = decode(cpu_addr);
    assign cpu_we = cpu_write && !cpu_blocked;

`ifdef GB_BUS_DMA_EN
    logic [7:0]  dma_reg_q;
    logic [15:0] dma_src, dma_dst;
    logic [7:0]  dma_wdata, dma_src_data;
    logic        dma_rd, dma_we, dma_busy, dma_src_wram;

    assign dma_src_wram = (dma_src[15:8] >= 8'hC0) && (dma_src[15:8] <= 8'hFD);
    assign dma_src_data = dma_src_wram ? wram_q[dma_src[12:0]] : ext_rdata;

    oam_dma u_dma (
        .clk        (clk),
        .rst        (rst),
        .start_i    (cpu_we && region == R_DMA),
        .src_hi_i   (cpu_wdata),
        .src_data_i (dma_src_data),
        .src_addr_o (dma_src),
        .dst_addr_o (dma_dst),
        .wdata_o    (dma_wdata),
        .rd_o       (dma_rd),
        .we_o       (dma_we),
        .active_o   (dma_busy)
    );

    // Blocking uses the raw FSM flag so a reset cycle never lets a stray write through.
    assign cpu_blocked = dma_busy && (cpu_addr < HRAM_BASE);
    assign dma_active  = dma_busy && rst;

    always_ff @(posedge clk) begin
        if (!rst)                        dma_reg_q <= '0;
        else if (cpu_we && region == R_DMA) dma_reg_q <= cpu_wdata;
    end
`else
    assign cpu_blocked = 1'b0;
    assign dma_active  = 1'b0;
`endif

    always_comb begin
        ext_addr  = cpu_addr;
        ext_wdata = cpu_wdata;
        ext_we    = cpu_we && (region == R_EXT);
`ifdef GB_BUS_DMA_EN
        if (dma_we) begin
            ext_addr  = dma_dst;
            ext_wdata = dma_wdata;
            ext_we    = 1'b1;
        end else if (dma_rd && !dma_src_wram) begin
            ext_addr = dma_src;
            ext_we   = 1'b0;
        end
`endif
        if (!rst) ext_we = 1'b0;
    end

    always_comb begin
        cpu_rdata = 8'hFF;
        if (!cpu_blocked) begin
            case (region)
                R_EXT:  cpu_rdata = ext_rdata;
                R_WRAM: cpu_rdata = wram_q[cpu_addr[12:0]];
                R_IF:   cpu_rdata = {3'b111, if_q};
`ifdef GB_BUS_DMA_EN
                R_DMA:  cpu_rdata = dma_reg_q;
`endif
                R_HRAM: cpu_rdata = hram_q[cpu_addr[6:0]];
                R_IE:   cpu_rdata = ie_q;
                default: cpu_rdata = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_we && region == R_WRAM) wram_q[cpu_addr[12:0]] <= cpu_wdata;
        if (cpu_we && region == R_HRAM) hram_q[cpu_addr[6:0]]  <= cpu_wdata;
    end

    // Write, then ack, then request: a request always survives the same cycle.
    always_comb begin
        if_d = if_q;
        if (cpu_we && region == R_IF) if_d = cpu_wdata[4:0];
        if_d = (if_d & ~irq_ack) | irq_req;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if_q <= '0;
            ie_q <= '0;
        end else begin
            if_q <= if_d;
            if (cpu_we && region == R_IE) ie_q <= cpu_wdata;
        end
    end

    assign irq_pending = ie_q[4:0] & if_q;

endmodule

// File: tb/tb_gb_bus.sv
// Scoreboard bench for gb_bus: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_gb_bus;

`ifdef GB_BUS_DMA_EN
    localparam bit DMA_EN = 1'b1;
`else
    localparam bit DMA_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_rdata;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_we;
    logic [7:0]  ext_rdata;
    logic [4:0]  irq_req = '0;
    logic [4:0]  irq_ack = '0;
    logic [4:0]  irq_pending;
    logic        dma_active;

    gb_bus dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_write(cpu_write), .cpu_rdata(cpu_rdata), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_we(ext_we), .ext_rdata(ext_rdata),
        .irq_req(irq_req), .irq_ack(irq_ack), .irq_pending(irq_pending),
        .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External device: a fixed pattern derived from the address.
    function automatic logic [7:0] ext_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    assign ext_rdata = ext_fn(ext_addr);

    typedef struct { int unsigned c; logic [15:0] a; logic [7:0] d; } acc_t;
    typedef struct { int unsigned c; logic [4:0] p; logic act; } cyc_t;

    acc_t ext_q[$];
    acc_t rd_q[$];
    cyc_t cyc_q[$];

    int ncmp = 0;
    int nerr = 0;
    bit done = 1'b0;
    bit fin = 1'b0;

    // Reference model state
    logic [7:0]  wram_m [8192];
    logic [7:0]  hram_m [127];
    logic [4:0]  if_m = '0;
    logic [7:0]  ie_m = '0;
    logic [7:0]  dma_m = '0;
    bit          dma_on = 1'b0;
    int unsigned dma_c = 0;

    function automatic logic [7:0] exp_read(input logic [15:0] a, input bit blk);
        if (blk) return 8'hFF;
        if (a < 16'hC000) return ext_fn(a);
        if (a < 16'hFE00) return wram_m[int'(a & 16'h1FFF)];
        if (a < 16'hFEA0) return ext_fn(a);
        if (a < 16'hFF00) return 8'hFF;
        if (a == 16'hFF0F) return {3'b111, if_m};
        if (DMA_EN && a == 16'hFF46) return dma_m;
        if (a < 16'hFF80) return ext_fn(a);
        if (a == 16'hFFFF) return ie_m;
        return hram_m[int'(a) - 16'hFF80];
    endfunction

    task automatic op(input logic [15:0] a, input logic [7:0] d, input bit w, input bit r,
                      input logic [4:0] req, input logic [4:0] ack, input bit rs);
        int unsigned c;
        bit act, blk;
        logic [4:0] nif;
        logic [15:0] s;
        acc_t keep[$];
        @(posedge clk);
        #1;
        c = cyc;
        act = dma_on && (c >= dma_c + 1) && (c <= dma_c + 320);
        blk = act && (a < 16'hFF80);
        rst = rs;
        cpu_addr = a;
        cpu_wdata = d;
        cpu_write = w;
        irq_req = req;
        irq_ack = ack;
        cyc_q.push_back('{c, ie_m[4:0] & if_m, act && rs});
        if (!rs) begin
            foreach (ext_q[i]) if (ext_q[i].c < c) keep.push_back(ext_q[i]);
            ext_q = keep;
            if_m = '0; ie_m = '0; dma_m = '0; dma_on = 1'b0;
            return;
        end
        if (r) rd_q.push_back('{c, a, exp_read(a, blk)});
        nif = if_m;
        if (w && !blk) begin
            if (a >= 16'hC000 && a < 16'hFE00) wram_m[int'(a & 16'h1FFF)] = d;
            else if (a == 16'hFF0F) nif = d[4:0];
            else if (a == 16'hFFFF) ie_m = d;
            else if (a >= 16'hFF80) hram_m[int'(a) - 16'hFF80] = d;
            else if (DMA_EN && a == 16'hFF46) begin
                dma_m = d;
                dma_on = 1'b1;
                dma_c = c;
                for (int unsigned i = 0; i < 160; i++) begin
                    s = {d, 8'(i)};
                    ext_q.push_back('{c + 2 + 2 * i, 16'hFE00 + 16'(i),
                        (d >= 8'hC0 && d <= 8'hFD) ? wram_m[int'(s & 16'h1FFF)] : ext_fn(s)});
                end
            end else if (a < 16'hFEA0 || (a >= 16'hFF00 && a < 16'hFF80))
                ext_q.push_back('{c, a, d});
        end
        if_m = (nif & ~ack) | req;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        op(a, d, 1'b1, 1'b0, '0, '0, 1'b1);
    endtask
    task automatic rd(input logic [15:0] a);
        op(a, 8'h00, 1'b0, 1'b1, '0, '0, 1'b1);
    endtask
    task automatic idle();
        op(16'h0000, 8'h00, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    function automatic logic [15:0] rnd_addr();
        logic [15:0] a;
        case ($urandom_range(0, 9))
            0: a = 16'($urandom_range(16'h0000, 16'hBFFF));
            1: a = 16'($urandom_range(16'hC000, 16'hDFFF));
            2: a = 16'($urandom_range(16'hE000, 16'hFDFF));
            3: a = 16'($urandom_range(16'hFE00, 16'hFE9F));
            4: a = 16'($urandom_range(16'hFEA0, 16'hFEFF));
            5: a = 16'($urandom_range(16'hFF00, 16'hFF7F));
            6: a = 16'hFF0F;
            8: a = 16'hFFFF;
            default: a = 16'($urandom_range(16'hFF80, 16'hFFFE));
        endcase
        if (a == 16'hFF46) a = 16'hFF47;
        return a;
    endfunction

    task automatic rnd_ops(input int n);
        logic [15:0] a;
        bit w;
        for (int i = 0; i < n; i++) begin
            a = rnd_addr();
            w = 1'($urandom_range(0, 1));
            op(a, 8'($urandom), w, !w,
               ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00,
               ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00, 1'b1);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        while (ext_q.size() > 0 && ext_q[0].c < cyc) begin
            ncmp++; nerr++;
            $display("FAIL ext_missing cyc=%0d: no write seen, required addr=%h data=%h at cyc %0d",
                     cyc, ext_q[0].a, ext_q[0].d, ext_q[0].c);
            void'(ext_q.pop_front());
        end
        if (ext_we === 1'b1) begin
            ncmp++;
            if (ext_q.size() == 0 || ext_q[0].c != cyc) begin
                nerr++;
                $display("FAIL ext_unexpected cyc=%0d: got we=1 addr=%h data=%h, required we=0",
                         cyc, ext_addr, ext_wdata);
            end else begin
                if (ext_addr !== ext_q[0].a || ext_wdata !== ext_q[0].d) begin
                    nerr++;
                    $display("FAIL ext_write cyc=%0d: got addr=%h data=%h, required addr=%h data=%h",
                             cyc, ext_addr, ext_wdata, ext_q[0].a, ext_q[0].d);
                end
                void'(ext_q.pop_front());
            end
        end
        while (rd_q.size() > 0 && rd_q[0].c <= cyc) begin
            if (rd_q[0].c == cyc) begin
                ncmp++;
                if (cpu_rdata !== rd_q[0].d) begin
                    nerr++;
                    $display("FAIL cpu_read cyc=%0d addr=%h: got %h, required %h",
                             cyc, rd_q[0].a, cpu_rdata, rd_q[0].d);
                end
            end
            void'(rd_q.pop_front());
        end
        while (cyc_q.size() > 0 && cyc_q[0].c <= cyc) begin
            if (cyc_q[0].c == cyc) begin
                ncmp += 2;
                if (irq_pending !== cyc_q[0].p) begin
                    nerr++;
                    $display("FAIL irq_pending cyc=%0d: got %h, required %h", cyc, irq_pending, cyc_q[0].p);
                end
                if (dma_active !== cyc_q[0].act) begin
                    nerr++;
                    $display("FAIL dma_active cyc=%0d: got %b, required %b", cyc, dma_active, cyc_q[0].act);
                end
            end
            void'(cyc_q.pop_front());
        end
        if (done && !fin) begin
            fin = 1'b1;
            ncmp++;
            if (ext_q.size() != 0) begin
                nerr++;
                $display("FAIL ext_drain: got %0d outstanding writes, required 0", ext_q.size());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);

        // Reset state
        rd(16'hFF0F);
        rd(16'hFFFF);
        if (DMA_EN) rd(16'hFF46);

        // Fill WRAM (first 160 bytes = index) and HRAM
        for (int unsigned i = 0; i < 8192; i++)
            wr(16'hC000 + 16'(i), (i < 160) ? 8'(i) : 8'($urandom));
        for (int unsigned i = 0; i < 127; i++)
            wr(16'hFF80 + 16'(i), 8'($urandom));

        // Echo, HRAM, unused region
        wr(16'hC123, 8'h5A);
        rd(16'hE123);
        wr(16'hFF90, 8'h3C);
        rd(16'hFF90);
        rd(16'hFEA5);
        wr(16'hFEA5, 8'h77);
        rd(16'hFEA5);
        wr(16'h1234, 8'hAB);
        rd(16'h4321);

        // Interrupts: request beats a simultaneous IF write, then ack clears it
        wr(16'hFFFF, 8'h1F);
        op(16'hFF0F, 8'h00, 1'b1, 1'b0, 5'h04, 5'h00, 1'b1);
        rd(16'hFF0F);
        op(16'h0000, 8'h00, 1'b0, 1'b0, 5'h00, 5'h04, 1'b1);
        rd(16'hFF0F);
        op(16'hFF0F, 8'h00, 1'b0, 1'b1, 5'h03, 5'h03, 1'b1);
        rd(16'hFF0F);

        rnd_ops(600);

        if (DMA_EN) begin
            // Full DMA from WRAM with CPU traffic in flight
            wr(16'hFF46, 8'hC0);
            rd(16'hC000);
            rd(16'hFF80);
            rd(16'hFF46);
            rnd_ops(330);
            rd(16'hFF46);

            // External source, aborted by reset at N+51
            wr(16'hFF46, 8'h40);
            repeat (50) idle();
            op(16'h0000, 8'h00, 1'b0, 1'b0, '0, '0, 1'b0);
            rd(16'hFF0F);
            rd(16'hFF46);
            rd(16'hFFFF);
            repeat (4) idle();
        end else begin
            wr(16'hFF46, 8'h12);
            rd(16'hFF46);
        end

        rnd_ops(200);
        repeat (4) idle();
        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
